// File: rtl/sig_gen_pkg.sv
// Shared types and default widths for the two-channel wavetable sequencer.
package sig_gen_pkg;

    localparam int unsigned DEF_ADDRESS_WIDTH = 8;
    localparam int unsigned DEF_DATA_WIDTH    = 8;
    localparam int unsigned DEF_DIV_WIDTH     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE0 = 2'd1,
        ST_ISSUE1 = 2'd2,
        ST_CAP1   = 2'd3
    } wave_state_e;

endpackage

// File: rtl/tick_gen.sv
// Sample-rate prescaler: counts 0..div and fires a one-cycle tick on the last count.
module tick_gen
    import sig_gen_pkg::*;
#(
    parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    // Disabling parks the count at zero so a re-enable always starts a full period.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == div) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en & (cnt_q == div);

endmodule

// File: rtl/wave_seq.sv
// Two-channel DDS sequencer sharing one synchronous ROM; both channel lookups
// are serialised per tick and published together on sample_valid.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | waiting for a tick; channel-0 address issued on tick
//   ST_ISSUE0 | channel-0 read in flight; channel-1 address issued
//   ST_ISSUE1 | channel-0 data on rom_dout, latched into hold0
//   ST_CAP1   | channel-1 data on rom_dout; outputs and phases update
module wave_seq
    import sig_gen_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int DIV_WIDTH     = DEF_DIV_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DIV_WIDTH-1:0]     div,
    input  logic [ADDRESS_WIDTH-1:0] incr0,
    input  logic [ADDRESS_WIDTH-1:0] incr1,
    input  logic [ADDRESS_WIDTH-1:0] phase1,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_dout,
    output logic [DATA_WIDTH-1:0]    dout0,
    output logic [DATA_WIDTH-1:0]    dout1,
    output logic                     sample_valid,
    output logic                     overrun
);

    logic tick;

    wave_state_e              state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] acc0_q, acc0_d;
    logic [ADDRESS_WIDTH-1:0] acc1_q, acc1_d;
    logic [ADDRESS_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_WIDTH-1:0]    hold0_q, hold0_d;
    logic [DATA_WIDTH-1:0]    dout0_q, dout0_d;
    logic [DATA_WIDTH-1:0]    dout1_q, dout1_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;

    tick_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .div (div),
        .tick(tick)
    );

    always_comb begin
        state_d    = state_q;
        acc0_d     = acc0_q;
        acc1_d     = acc1_q;
        rom_addr_d = rom_addr_q;
        hold0_d    = hold0_q;
        dout0_d    = dout0_q;
        dout1_d    = dout1_q;
        valid_d    = 1'b0;
        // A tick can only be taken in IDLE; anywhere else it is lost.
        overrun_d  = overrun_q | (tick & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    rom_addr_d = acc0_q;
                    state_d    = ST_ISSUE0;
                end
            end
            ST_ISSUE0: begin
                rom_addr_d = acc1_q + phase1;
                state_d    = ST_ISSUE1;
            end
            ST_ISSUE1: begin
                hold0_d = rom_dout;
                state_d = ST_CAP1;
            end
            ST_CAP1: begin
                dout0_d = hold0_q;
                dout1_d = rom_dout;
                valid_d = 1'b1;
                acc0_d  = acc0_q + incr0;
                acc1_d  = acc1_q + incr1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc0_q     <= '0;
            acc1_q     <= '0;
            rom_addr_q <= '0;
            hold0_q    <= '0;
            dout0_q    <= '0;
            dout1_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc0_q     <= acc0_d;
            acc1_q     <= acc1_d;
            rom_addr_q <= rom_addr_d;
            hold0_q    <= hold0_d;
            dout0_q    <= dout0_d;
            dout1_q    <= dout1_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign dout0        = dout0_q;
    assign dout1        = dout1_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_wave_seq.sv
// Self-checking bench for wave_seq with a local synchronous ROM and a
// tick/sample reference model derived from the sequencing rules.
module tb_wave_seq;

    localparam int MAXC = 64;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] div;
    logic [7:0]  incr0, incr1, phase1;
    logic [7:0]  rom_addr, rom_dout;
    logic [7:0]  dout0, dout1;
    logic        sample_valid, overrun;

    logic [7:0]  mem [256];

    int passed = 0;
    int total  = 0;

    logic        exp_v  [MAXC];
    logic        exp_ov [MAXC];
    logic [7:0]  exp_d0 [MAXC];
    logic [7:0]  exp_d1 [MAXC];

    wave_seq dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .div         (div),
        .incr0       (incr0),
        .incr1       (incr1),
        .phase1      (phase1),
        .rom_addr    (rom_addr),
        .rom_dout    (rom_dout),
        .dout0       (dout0),
        .dout1       (dout1),
        .sample_valid(sample_valid),
        .overrun     (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rom_dout <= mem[rom_addr];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of cycle 0 (first cycle after reset released).
    task automatic start_run(input int dv, input logic [7:0] i0, input logic [7:0] i1,
                             input logic [7:0] ph);
        rst    = 1'b1;
        en     = 1'b1;
        div    = dv[15:0];
        incr0  = i0;
        incr1  = i1;
        phase1 = ph;
        step();
        rst = 1'b0;
    endtask

    task automatic fill_identity();
        for (int i = 0; i < 256; i++) mem[i] = i[7:0];
    endtask

    // Ticks land every div+1 cycles; a tick is accepted only once the previous
    // accepted tick is 4 cycles old, its sample appears 4 cycles later.
    function automatic void build_model(input int dv, input logic [7:0] i0,
                                        input logic [7:0] i1, input logic [7:0] ph,
                                        input int n);
        logic [7:0] a0, a1, idx, d0, d1;
        logic [7:0] p0 [MAXC];
        logic [7:0] p1 [MAXC];
        int free_at, ov_from;
        a0 = 8'h00; a1 = 8'h00; d0 = 8'h00; d1 = 8'h00;
        free_at = 0;
        ov_from = MAXC + 1;
        for (int c = 0; c < MAXC; c++) begin
            exp_v[c] = 1'b0; p0[c] = 8'h00; p1[c] = 8'h00;
        end
        for (int t = 0; t < n; t++) begin
            if (t % (dv + 1) == dv) begin
                if (t >= free_at) begin
                    if (t + 4 < MAXC) begin
                        exp_v[t+4] = 1'b1;
                        p0[t+4]    = mem[a0];
                        idx        = a1 + ph;
                        p1[t+4]    = mem[idx];
                    end
                    a0      = a0 + i0;
                    a1      = a1 + i1;
                    free_at = t + 4;
                end else if (t + 1 < ov_from) begin
                    ov_from = t + 1;
                end
            end
        end
        for (int c = 0; c < MAXC; c++) begin
            if (exp_v[c]) begin
                d0 = p0[c];
                d1 = p1[c];
            end
            exp_d0[c] = d0;
            exp_d1[c] = d1;
            exp_ov[c] = (c >= ov_from);
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; div = 16'd0;
        incr0 = 8'h11; incr1 = 8'h22; phase1 = 8'h33;
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if ({rom_addr, dout0, dout1, sample_valid, overrun} !== 26'd0)
                $display("FAIL reset cyc %0d: got addr=%h d0=%h d1=%h v=%b ov=%b want all 0",
                         c, rom_addr, dout0, dout1, sample_valid, overrun);
            else passed++;
        end
    endtask

    task automatic test_basic();
        int         pc[$];
        logic [7:0] q0[$];
        logic [7:0] q1[$];
        logic [7:0] e0 [3];
        logic [7:0] e1 [3];
        e0 = '{8'h00, 8'h01, 8'h02};
        e1 = '{8'h40, 8'h42, 8'h44};
        fill_identity();
        build_model(7, 8'h01, 8'h02, 8'h40, 30);
        start_run(7, 8'h01, 8'h02, 8'h40);
        for (int c = 0; c < 30; c++) begin
            total++;
            if ({sample_valid, overrun, dout0, dout1} !== {exp_v[c], exp_ov[c], exp_d0[c], exp_d1[c]})
                $display("FAIL basic cyc %0d: got v=%b ov=%b d0=%h d1=%h want v=%b ov=%b d0=%h d1=%h",
                         c, sample_valid, overrun, dout0, dout1, exp_v[c], exp_ov[c], exp_d0[c], exp_d1[c]);
            else passed++;
            if (sample_valid === 1'b1) begin
                pc.push_back(c); q0.push_back(dout0); q1.push_back(dout1);
            end
            step();
        end
        total++;
        if (pc.size() != 3) $display("FAIL basic_count: got %0d pulses want 3", pc.size());
        else passed++;
        for (int k = 0; k < 3 && k < pc.size(); k++) begin
            total++;
            if (pc[k] != 11 + 8 * k || q0[k] !== e0[k] || q1[k] !== e1[k])
                $display("FAIL basic_pulse %0d: got cyc=%0d (%h,%h) want cyc=%0d (%h,%h)",
                         k, pc[k], q0[k], q1[k], 11 + 8 * k, e0[k], e1[k]);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] got[$];
        logic [7:0] e0 [3];
        e0 = '{8'h00, 8'hFF, 8'hFE};
        fill_identity();
        start_run(3, 8'hFF, 8'h00, 8'h00);
        for (int c = 0; c < 16; c++) begin
            if (sample_valid === 1'b1) got.push_back(dout0);
            step();
        end
        total++;
        if (got.size() != 3) $display("FAIL wrap_count: got %0d pulses want 3", got.size());
        else passed++;
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            total++;
            if (got[k] !== e0[k]) $display("FAIL wrap %0d: got d0=%h want %h", k, got[k], e0[k]);
            else passed++;
        end
    endtask

    task automatic test_overrun();
        fill_identity();
        build_model(1, 8'h03, 8'h05, 8'h10, 30);
        start_run(1, 8'h03, 8'h05, 8'h10);
        for (int c = 0; c < 30; c++) begin
            total++;
            if ({sample_valid, overrun, dout0, dout1} !== {exp_v[c], exp_ov[c], exp_d0[c], exp_d1[c]})
                $display("FAIL overrun cyc %0d: got v=%b ov=%b d0=%h d1=%h want v=%b ov=%b d0=%h d1=%h",
                         c, sample_valid, overrun, dout0, dout1, exp_v[c], exp_ov[c], exp_d0[c], exp_d1[c]);
            else passed++;
            step();
        end
        total++;
        if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", overrun);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int npulse = 0;
        fill_identity();
        build_model(3, 8'h07, 8'h09, 8'h80, 24);
        start_run(3, 8'h07, 8'h09, 8'h80);
        for (int c = 0; c < 24; c++) begin
            total++;
            if ({sample_valid, overrun, dout0, dout1} !== {exp_v[c], exp_ov[c], exp_d0[c], exp_d1[c]})
                $display("FAIL b2b cyc %0d: got v=%b ov=%b d0=%h d1=%h want v=%b ov=%b d0=%h d1=%h",
                         c, sample_valid, overrun, dout0, dout1, exp_v[c], exp_ov[c], exp_d0[c], exp_d1[c]);
            else passed++;
            if (sample_valid === 1'b1) npulse++;
            step();
        end
        total++;
        if (npulse != 5 || overrun !== 1'b0)
            $display("FAIL b2b_summary: got pulses=%0d ov=%b want pulses=5 ov=0", npulse, overrun);
        else passed++;
    endtask

    task automatic test_reset_mid();
        fill_identity();
        build_model(7, 8'h01, 8'h02, 8'h40, 17);
        start_run(7, 8'h01, 8'h02, 8'h40);
        for (int c = 0; c < 17; c++) begin
            total++;
            if ({sample_valid, dout0, dout1} !== {exp_v[c], exp_d0[c], exp_d1[c]})
                $display("FAIL rstmid_pre cyc %0d: got v=%b d0=%h d1=%h want v=%b d0=%h d1=%h",
                         c, sample_valid, dout0, dout1, exp_v[c], exp_d0[c], exp_d1[c]);
            else passed++;
            step();
        end
        // cycle 17 is ISSUE1 of the second sequence
        rst = 1'b1;
        step();
        total++;
        if ({rom_addr, dout0, dout1, sample_valid, overrun} !== 26'd0)
            $display("FAIL rstmid_zero: got addr=%h d0=%h d1=%h v=%b ov=%b want all 0",
                     rom_addr, dout0, dout1, sample_valid, overrun);
        else passed++;
        rst = 1'b0;
        build_model(7, 8'h01, 8'h02, 8'h40, 20);
        for (int c = 0; c < 20; c++) begin
            total++;
            if ({sample_valid, overrun, dout0, dout1} !== {exp_v[c], exp_ov[c], exp_d0[c], exp_d1[c]})
                $display("FAIL rstmid_post cyc %0d: got v=%b ov=%b d0=%h d1=%h want v=%b ov=%b d0=%h d1=%h",
                         c, sample_valid, overrun, dout0, dout1, exp_v[c], exp_ov[c], exp_d0[c], exp_d1[c]);
            else passed++;
            step();
        end
    endtask

    task automatic test_en_drop();
        fill_identity();
        start_run(7, 8'h01, 8'h02, 8'h40);
        for (int c = 0; c < 8; c++) step();
        en = 1'b0;
        for (int c = 8; c < 41; c++) begin
            total++;
            if ({sample_valid, overrun, dout0, dout1} !==
                {(c == 11), 1'b0, 8'h00, (c >= 11) ? 8'h40 : 8'h00})
                $display("FAIL endrop cyc %0d: got v=%b ov=%b d0=%h d1=%h want v=%b ov=0 d0=00 d1=%h",
                         c, sample_valid, overrun, dout0, dout1, (c == 11), (c >= 11) ? 8'h40 : 8'h00);
            else passed++;
            step();
        end
        en = 1'b1;
        for (int c = 41; c < 56; c++) begin
            total++;
            if (sample_valid !== (c == 52))
                $display("FAIL enresume cyc %0d: got v=%b want %b", c, sample_valid, (c == 52));
            else passed++;
            if (c == 52) begin
                total++;
                if (dout0 !== 8'h01 || dout1 !== 8'h42)
                    $display("FAIL enresume_data: got (%h,%h) want (01,42)", dout0, dout1);
                else passed++;
            end
            step();
        end
    endtask

    task automatic test_random();
        int         dv;
        logic [7:0] i0, i1, ph;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            dv = int'($urandom_range(0, 9));
            i0 = 8'($urandom); i1 = 8'($urandom); ph = 8'($urandom);
            build_model(dv, i0, i1, ph, 60);
            start_run(dv, i0, i1, ph);
            for (int c = 0; c < 60; c++) begin
                total++;
                if ({sample_valid, overrun, dout0, dout1} !== {exp_v[c], exp_ov[c], exp_d0[c], exp_d1[c]})
                    $display("FAIL random it%0d div=%0d cyc %0d: got v=%b ov=%b d0=%h d1=%h want v=%b ov=%b d0=%h d1=%h",
                             it, dv, c, sample_valid, overrun, dout0, dout1,
                             exp_v[c], exp_ov[c], exp_d0[c], exp_d1[c]);
                else passed++;
                step();
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; div = 16'd0;
        incr0 = 8'h00; incr1 = 8'h00; phase1 = 8'h00;
        fill_identity();
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_en_drop();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
